// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - register file access bus
//
// Purpose: groups the read, write, reservation and status signals that
// pass between the issue/ALU side (master) and the register file (slave).
//
// Signals:
//   src1, src2      master->slave  read addresses
//   dest, data_in   master->slave  write address / data
//   write_enable    master->slave  commit data_in to dest at next edge
//   reserve_en      master->slave  mark reserve_addr pending
//   reserve_addr    master->slave  register to reserve
//   alu_out1/2      slave->master  combinational read data
//   pending1/2      slave->master  pending bit of src1/src2
//   busy            slave->master  clear sequencer running
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] data_in;
  logic              write_enable;
  logic              reserve_en;
  logic [ADDR_W-1:0] reserve_addr;
  logic [DATA_W-1:0] alu_out1;
  logic [DATA_W-1:0] alu_out2;
  logic              pending1;
  logic              pending2;
  logic              busy;

  modport master (
    output src1, src2, dest, data_in, write_enable, reserve_en, reserve_addr,
    input  alu_out1, alu_out2, pending1, pending2, busy
  );

  modport slave (
    input  src1, src2, dest, data_in, write_enable, reserve_en, reserve_addr,
    output alu_out1, alu_out2, pending1, pending2, busy
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with clear sequencer and pending scoreboard
//
// Purpose: DEPTH = 2**ADDR_W registers of DATA_W bits, two combinational
// read ports, one synchronous write port, a hardware clear sequence after
// reset, optional hardwired zero register, optional write-to-read bypass
// and a per-register pending bit for in-flight results.
//
// Ports:
//   clk  input   system clock, rising edge
//   rst  input   synchronous active-high reset
//   rf   slave   register file bus (see regfile_param_if)
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_param_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]    pending_q, pending_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                busy;
  logic                wr_ok;
  logic                res_ok;

  assign busy = (state_q == CLEAR);

  // Writes and reservations aimed at a hardwired zero register are dropped
  // here, so neither the array, the scoreboard nor the bypass ever sees them.
  assign wr_ok  = rf.write_enable && !((ZERO_REG != 0) && (rf.dest == '0));
  assign res_ok = rf.reserve_en && !((ZERO_REG != 0) && (rf.reserve_addr == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pending_d = pending_q;
    mem_we    = 1'b0;
    mem_waddr = rf.dest;
    mem_wdata = rf.data_in;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = READY;
        end
      end
      READY: begin
        if (wr_ok) begin
          mem_we            = 1'b1;
          pending_d[rf.dest] = 1'b0;
        end
        // Applied after the write clear so a same-address reserve wins.
        if (res_ok) begin
          pending_d[rf.reserve_addr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase

    // Reset leaves the array untouched; the clear sequence that follows
    // zeroes it.
    if (rst) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      pending_d = '0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
    pending_q <= pending_d;
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] rd1, rd2;

  always_comb begin
    rd1 = mem_q[rf.src1];
    rd2 = mem_q[rf.src2];
    if ((ZERO_REG != 0) && (rf.src1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (rf.src2 == '0)) rd2 = '0;
    if ((BYPASS != 0) && wr_ok && (rf.dest == rf.src1)) rd1 = rf.data_in;
    if ((BYPASS != 0) && wr_ok && (rf.dest == rf.src2)) rd2 = rf.data_in;
    if (busy) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign rf.alu_out1 = rd1;
  assign rf.alu_out2 = rd2;
  // Pending is deliberately not bypassed: a result landing this cycle is
  // still reported in flight until the edge.
  assign rf.pending1 = busy ? 1'b0 : pending_q[rf.src1];
  assign rf.pending2 = busy ? 1'b0 : pending_q[rf.src2];
  assign rf.busy     = busy;
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard testbench for regfile_param
module tb_regfile_param;
  localparam int S_BUSY = 0;
  localparam int S_OUT1 = 1;
  localparam int S_OUT2 = 2;
  localparam int S_PND1 = 3;
  localparam int S_PND2 = 4;

  typedef struct {
    string       name;
    int          dut;
    int          sig;
    logic [31:0] exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: 16x16, no zero reg, bypass; u1: 16x16, zero reg, no bypass; u2: 32x32
  regfile_param_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  regfile_param_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) if2 ();

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .rf(if0));
  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .rf(if1));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .rf(if2));

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int dut, input int sig,
                            input logic [31:0] exp);
    sb_item_t it;
    it.name = name;
    it.dut  = dut;
    it.sig  = sig;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  function automatic logic [31:0] actual(input int dut, input int sig);
    logic [31:0] v;
    v = 'x;
    case (dut)
      0: case (sig)
           S_BUSY: v = 32'(if0.busy);
           S_OUT1: v = 32'(if0.alu_out1);
           S_OUT2: v = 32'(if0.alu_out2);
           S_PND1: v = 32'(if0.pending1);
           default: v = 32'(if0.pending2);
         endcase
      1: case (sig)
           S_BUSY: v = 32'(if1.busy);
           S_OUT1: v = 32'(if1.alu_out1);
           S_OUT2: v = 32'(if1.alu_out2);
           S_PND1: v = 32'(if1.pending1);
           default: v = 32'(if1.pending2);
         endcase
      default: case (sig)
           S_BUSY: v = 32'(if2.busy);
           S_OUT1: v = if2.alu_out1;
           S_OUT2: v = if2.alu_out2;
           S_PND1: v = 32'(if2.pending1);
           default: v = 32'(if2.pending2);
         endcase
    endcase
    return v;
  endfunction

  // Monitor: drains the scoreboard on the falling edge, away from the
  // edge where the stimulus changes inputs.
  sb_item_t    mon_item;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      mon_item = sb_q.pop_front();
      mon_act  = actual(mon_item.dut, mon_item.sig);
      checks++;
      if (mon_act !== mon_item.exp) begin
        errors++;
        $display("FAIL %s (u%0d): got %h expected %h", mon_item.name,
                 mon_item.dut, mon_act, mon_item.exp);
      end
    end
  end

  task automatic idle_all();
    if0.src1 = '0; if0.src2 = '0; if0.dest = '0; if0.data_in = '0;
    if0.write_enable = 1'b0; if0.reserve_en = 1'b0; if0.reserve_addr = '0;
    if1.src1 = '0; if1.src2 = '0; if1.dest = '0; if1.data_in = '0;
    if1.write_enable = 1'b0; if1.reserve_en = 1'b0; if1.reserve_addr = '0;
    if2.src1 = '0; if2.src2 = '0; if2.dest = '0; if2.data_in = '0;
    if2.write_enable = 1'b0; if2.reserve_en = 1'b0; if2.reserve_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (3) step();
    expect_val("rst_busy", 0, S_BUSY, 32'd1);
    expect_val("rst_out1", 0, S_OUT1, 32'd0);
    expect_val("rst_pnd1", 0, S_PND1, 32'd0);
    expect_val("rst_busy", 2, S_BUSY, 32'd1);
    rst = 1'b0;

    // First clear interrupted after 8 edges
    for (int i = 0; i < 8; i++) begin
      expect_val("clr_a_busy", 0, S_BUSY, 32'd1);
      step();
    end
    rst = 1'b1;
    expect_val("clr_rst_busy", 0, S_BUSY, 32'd1);
    step();
    rst = 1'b0;

    // Full restarted clear; writes/reserves to r5 must be ignored
    if0.write_enable = 1'b1; if0.dest = 4'd5; if0.data_in = 16'hBEEF;
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd5; if0.src1 = 4'd5; if0.src2 = 4'd5;
    if1.write_enable = 1'b1; if1.dest = 4'd5; if1.data_in = 16'hBEEF;
    if1.src1 = 4'd5;
    for (int i = 0; i < 16; i++) begin
      expect_val("clr_b_busy", 0, S_BUSY, 32'd1);
      expect_val("clr_b_busy", 1, S_BUSY, 32'd1);
      expect_val("clr_b_out1", 0, S_OUT1, 32'd0);
      expect_val("clr_b_pnd1", 0, S_PND1, 32'd0);
      step();
    end
    idle_all();
    if0.src1 = 4'd5; if1.src1 = 4'd5;
    expect_val("clr_done_busy", 0, S_BUSY, 32'd0);
    expect_val("clr_done_busy", 1, S_BUSY, 32'd0);
    expect_val("clr_r5_lost", 0, S_OUT1, 32'd0);
    expect_val("clr_r5_pnd", 0, S_PND1, 32'd0);
    expect_val("clr_r5_lost", 1, S_OUT1, 32'd0);
    expect_val("clr32_busy", 2, S_BUSY, 32'd1);
    for (int i = 0; i < 16; i++) begin
      expect_val("clr32_busy", 2, S_BUSY, 32'd1);
      step();
    end
    expect_val("clr32_done", 2, S_BUSY, 32'd0);

    // Basic read/write
    if0.write_enable = 1'b1; if0.dest = 4'd3; if0.data_in = 16'h1234;
    if2.write_enable = 1'b1; if2.dest = 5'd31; if2.data_in = 32'hDEADBEEF;
    step();
    if2.write_enable = 1'b0;
    if0.dest = 4'd7; if0.data_in = 16'hABCD;
    step();
    idle_all();
    if0.src1 = 4'd3; if0.src2 = 4'd7;
    if2.src1 = 5'd31; if2.src2 = 5'd30;
    expect_val("rw_r3", 0, S_OUT1, 32'h1234);
    expect_val("rw_r7", 0, S_OUT2, 32'hABCD);
    expect_val("rw32_r31", 2, S_OUT1, 32'hDEADBEEF);
    expect_val("rw32_r30", 2, S_OUT2, 32'h0);
    step();

    // Bypass on u0, none on u1
    if0.write_enable = 1'b1; if0.dest = 4'd4; if0.data_in = 16'h5555;
    if0.src1 = 4'd4; if0.src2 = 4'd4;
    if1.write_enable = 1'b1; if1.dest = 4'd4; if1.data_in = 16'h5555;
    if1.src1 = 4'd4; if1.src2 = 4'd4;
    expect_val("byp_same_cyc1", 0, S_OUT1, 32'h5555);
    expect_val("byp_same_cyc2", 0, S_OUT2, 32'h5555);
    expect_val("nobyp_old1", 1, S_OUT1, 32'h0);
    expect_val("nobyp_old2", 1, S_OUT2, 32'h0);
    step();
    if0.write_enable = 1'b0; if1.write_enable = 1'b0;
    expect_val("byp_next1", 0, S_OUT1, 32'h5555);
    expect_val("nobyp_next1", 1, S_OUT1, 32'h5555);
    expect_val("nobyp_next2", 1, S_OUT2, 32'h5555);
    step();

    // Zero register
    idle_all();
    if0.write_enable = 1'b1; if0.dest = 4'd0; if0.data_in = 16'hFFFF;
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd0;
    if1.write_enable = 1'b1; if1.dest = 4'd0; if1.data_in = 16'hFFFF;
    if1.reserve_en = 1'b1; if1.reserve_addr = 4'd0;
    expect_val("zr_wcyc_out", 1, S_OUT1, 32'h0);
    step();
    idle_all();
    expect_val("zr_out", 1, S_OUT1, 32'h0);
    expect_val("zr_pnd", 1, S_PND1, 32'd0);
    expect_val("nzr_out", 0, S_OUT1, 32'hFFFF);
    expect_val("nzr_pnd", 0, S_PND1, 32'd1);
    step();

    // Scoreboard
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd9; if0.src1 = 4'd9;
    step();
    if0.reserve_en = 1'b0;
    expect_val("sb_res9", 0, S_PND1, 32'd1);
    step();
    if0.write_enable = 1'b1; if0.dest = 4'd9; if0.data_in = 16'h0909;
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd9;
    expect_val("sb_wcyc_pnd", 0, S_PND1, 32'd1);
    expect_val("sb_wcyc_byp", 0, S_OUT1, 32'h0909);
    step();
    if0.write_enable = 1'b0; if0.reserve_en = 1'b0;
    expect_val("sb_reswins", 0, S_PND1, 32'd1);
    expect_val("sb_reswins_data", 0, S_OUT1, 32'h0909);
    step();
    if0.write_enable = 1'b1; if0.data_in = 16'h0A0A;
    step();
    if0.write_enable = 1'b0;
    expect_val("sb_wr_clears", 0, S_PND1, 32'd0);
    expect_val("sb_wr_data", 0, S_OUT1, 32'h0A0A);
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd6;
    step();
    if0.reserve_addr = 4'd2;
    if0.write_enable = 1'b1; if0.dest = 4'd6; if0.data_in = 16'h0606;
    step();
    if0.reserve_en = 1'b0; if0.write_enable = 1'b0;
    if0.src1 = 4'd2; if0.src2 = 4'd6;
    expect_val("sb_res2", 0, S_PND1, 32'd1);
    expect_val("sb_wr6", 0, S_PND2, 32'd0);
    expect_val("sb_wr6_data", 0, S_OUT2, 32'h0606);

    // Reset mid-operation
    if0.reserve_en = 1'b1; if0.reserve_addr = 4'd1;
    step();
    if0.reserve_en = 1'b0;
    if0.src1 = 4'd1; if0.src2 = 4'd2;
    expect_val("mid_pnd1", 0, S_PND1, 32'd1);
    expect_val("mid_pnd2", 0, S_PND2, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_val("mid_rst_pnd1", 0, S_PND1, 32'd0);
    expect_val("mid_rst_pnd2", 0, S_PND2, 32'd0);
    for (int i = 0; i < 16; i++) begin
      expect_val("mid_busy", 0, S_BUSY, 32'd1);
      step();
    end
    if0.src1 = 4'd3; if0.src2 = 4'd7;
    expect_val("mid_done", 0, S_BUSY, 32'd0);
    expect_val("mid_r3_zero", 0, S_OUT1, 32'h0);
    expect_val("mid_r7_zero", 0, S_OUT2, 32'h0);
    step();
    if0.src1 = 4'd1; if0.src2 = 4'd2;
    expect_val("mid_pnd1_clr", 0, S_PND1, 32'd0);
    expect_val("mid_pnd2_clr", 0, S_PND2, 32'd0);
    expect_val("mid_r2_zero", 0, S_OUT2, 32'h0);
    step();
    step();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending items expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the 16x16 CPU register file, generalised in data width and address width. It keeps two combinational read ports and one synchronous write port feeding the ALU. New behaviour:
- hardware clear sequencer on reset, replacing memory-file initialisation;
- optional hardwired zero register;
- optional write-to-read bypass;
- per-register pending scoreboard so the issue logic can detect in-flight results.

Parameters:
DATA_W, 16, width of each register and of data_in/alu_out*
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers (derived, not overridable)
ZERO_REG, 0, 1 = register 0 always reads zero, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
src1  input  ADDR_W  read address, port 1
src2  input  ADDR_W  read address, port 2
dest  input  ADDR_W  write address
data_in  input  DATA_W  write data
write_enable  input  1  commit data_in to regFile[dest] at the next edge; clears pending[dest]
reserve_en  input  1  mark reserve_addr as pending (result in flight)
reserve_addr  input  ADDR_W  register to reserve
alu_out1  output  DATA_W  read data, port 1 (combinational)
alu_out2  output  DATA_W  read data, port 2 (combinational)
pending1  output  1  pending bit of src1 (combinational)
pending2  output  1  pending bit of src2 (combinational)
busy  output  1  1 while the clear sequencer runs; all other inputs ignored

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; the polarity and synchronicity are fixed.
- States: CLEAR, READY. The reset value of the state is CLEAR.
- rst sampled high: state<=CLEAR, clr_cnt<=0, all pending bits<=0.
  - Register contents are not touched in that cycle.
  - rst held high keeps clr_cnt at 0.
- CLEAR with rst low, each edge:
  - regFile[clr_cnt]<=0 and clr_cnt<=clr_cnt+1.
  - On the edge where clr_cnt==DEPTH-1, state<=READY. clr_cnt wraps to 0, which is harmless.
  - busy is therefore high for exactly DEPTH edges after the first rst-low edge. busy = (state==CLEAR).
- While busy (including during rst):
  - write_enable and reserve_en are ignored.
  - alu_out1/2 = 0 and pending1/2 = 0, regardless of array contents.
- Reset mid-clear restarts the sequence from clr_cnt=0; the full DEPTH-cycle clear follows.
- READY, write:
  - write_enable=1 -> regFile[dest]<=data_in at the edge.
  - If ZERO_REG=1 and dest==0, the write is discarded.
- READY, read:
  - alu_outN = regFile[srcN], combinational.
  - If ZERO_REG=1 and srcN==0, alu_outN = 0.
- Bypass (BYPASS=1 only):
  - Condition: write_enable=1, dest==srcN, and the write is not discarded.
  - Then alu_outN = data_in in the same cycle.
  - Both ports may bypass simultaneously.
  - BYPASS=0: reads return the old value until after the edge.
- Scoreboard, one bit per register:
  - reserve_en=1 -> pending[reserve_addr]<=1.
  - write_enable=1 -> pending[dest]<=0.
  - Same edge, same address: reserve wins, so pending=1 and data is still written.
  - Same edge, different addresses: both take effect.
  - ZERO_REG=1: reservations of address 0 are ignored, so pending[0] stays 0.
  - pendingN = pending[srcN]. There is no bypass on pending: a write this cycle still shows pending=1 until the edge.
- Widths: address compares use the full ADDR_W. No arithmetic on data. clr_cnt is ADDR_W bits.
- No X on any output after rst has been sampled once.

Test Plan:
- Clear sequence: rst high 3 cycles, then low -> busy=1 for exactly 16 edges then 0. Writes during busy to reg 5 (0xBEEF) are lost, so reg 5 reads 0x0000 after busy falls. With rst re-asserted at clear edge 8, busy stays high 16 more edges.
- Basic R/W: write 0x1234->r3, then 0xABCD->r7; src1=3, src2=7 -> alu_out1=0x1234, alu_out2=0xABCD. DATA_W=32, ADDR_W=5 instance: r31 <- 0xDEADBEEF reads back.
- Bypass: BYPASS=1, dest=src1=src2=4, data_in=0x5555 -> both outputs 0x5555 in the write cycle. BYPASS=0 -> old value (0x0000) that cycle, 0x5555 next.
- Zero reg: ZERO_REG=1, write 0xFFFF->r0 and reserve r0 -> alu_out1=0x0000, pending1=0. With ZERO_REG=0 the same stimulus gives 0xFFFF and pending=1.
- Scoreboard: reserve r9 -> pending1=1 (src1=9). Write r9 and reserve r9 on the same edge -> pending stays 1. Write r9 alone next -> pending1=0. Reserve r2 while writing r6 -> pending[2]=1, pending[6]=0.
- Reset mid-operation: pending r1,r2 set, data present, rst pulse -> pending1/2=0 immediately after the edge and all registers read 0 once busy falls.
